// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader_if
// Description : Bundles the FIFO first-word-fall-through read port and the
//               framed valid/ready output stream of fifo_burst_reader.
//               master = the burst reader, slave = FIFO + downstream sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_burst_reader_if #(
    parameter int DSIZE = 32
);
    // FIFO read port
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    // Framed output stream
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (
        input  rdata, rempty, m_ready,
        output rinc, m_valid, m_data, m_last
    );

    modport slave (
        output rdata, rempty, m_ready,
        input  rinc, m_valid, m_data, m_last
    );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Drains a FWFT FIFO read port through a hold register (H) and
//               an output register (O) into a framed valid/ready stream.
//               Frames close after BURST_LEN beats or after the FIFO has been
//               empty for TIMEOUT cycles. Counts completed frames.
//               Optional macro FIFO_BURST_READER_CHECKSUM_EN appends an XOR
//               checksum beat to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DSIZE     = 32,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16,
    parameter int CNTW      = 16
) (
    input  wire logic            rclk,
    input  wire logic            rrst,
    input  wire logic            en,
    fifo_burst_reader_if.master  bus,
    output logic [CNTW-1:0]      bursts_done,
    output logic                 busy
);
    localparam int BW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] c_beat_max = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0] c_idle_max = IW'(TIMEOUT);

    logic             r_h_valid;
    logic [DSIZE-1:0] r_h_data;
    logic             r_o_valid;
    logic [DSIZE-1:0] r_o_data;
    logic             r_o_last;
    logic [BW-1:0]    r_beat_cnt;
    logic [IW-1:0]    r_idle_cnt;
    logic [CNTW-1:0]  r_bursts;

    logic w_o_free, w_more, w_at_max, w_timeout, w_resolved, w_dec_last;
    logic w_stream, w_h_moves, w_pop, w_accept_last, w_move_last;

    // O can take a new beat when empty or when its beat leaves this cycle
    assign w_o_free      = ~r_o_valid | bus.m_ready;
    assign w_more        = ~bus.rempty & en;
    assign w_at_max      = (r_beat_cnt == c_beat_max);
    assign w_timeout     = (r_idle_cnt == c_idle_max);
    // Last-beat decision: full burst wins, then "more data follows", then timeout
    assign w_resolved    = w_at_max | w_more | w_timeout;
    assign w_dec_last    = w_at_max | (~w_more & w_timeout);
    assign w_h_moves     = r_h_valid & w_o_free & w_resolved & w_stream;
    assign w_pop         = en & ~bus.rempty & ~rrst & (~r_h_valid | w_h_moves);
    assign w_accept_last = r_o_valid & bus.m_ready & r_o_last;

    assign bus.rinc    = w_pop;
    assign bus.m_valid = r_o_valid;
    assign bus.m_data  = r_o_data;
    assign bus.m_last  = r_o_last;
    assign bursts_done = r_bursts;
    assign busy        = r_h_valid | r_o_valid | (r_beat_cnt != '0);

`ifdef FIFO_BURST_READER_CHECKSUM_EN
    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_CSUM   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DSIZE-1:0] r_acc;
    logic [DSIZE-1:0] w_acc_base;
    logic             w_csum_ins;

    // Data beats never carry last; the checksum beat closes the frame
    assign w_move_last = 1'b0;
    assign w_stream    = (r_state == ST_STREAM);
    assign w_csum_ins  = (r_state == ST_CSUM) & w_o_free;
    // A checksum accepted this cycle restarts the XOR for the next frame
    assign w_acc_base  = w_accept_last ? '0 : r_acc;

    // State register
    always_ff @(posedge rclk) begin
        if (rrst) r_state <= ST_STREAM;
        else      r_state <= w_state_nxt;
    end

    // Next state: enter CSUM after the closing data beat, leave once inserted
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STREAM: if (w_h_moves && w_dec_last) w_state_nxt = ST_CSUM;
            ST_CSUM:   if (w_o_free)                w_state_nxt = ST_STREAM;
            default:                                w_state_nxt = ST_STREAM;
        endcase
    end

    // XOR accumulator over the data words moved into O
    always_ff @(posedge rclk) begin
        if (rrst) r_acc <= '0;
        else      r_acc <= w_acc_base ^ (w_h_moves ? r_h_data : '0);
    end
`else
    assign w_move_last = w_dec_last;
    assign w_stream    = 1'b1;
`endif

    // Hold register: loads on pop, empties when its word moves to O
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_h_valid <= 1'b0;
            r_h_data  <= '0;
        end else if (w_pop) begin
            r_h_valid <= 1'b1;
            r_h_data  <= bus.rdata;
        end else if (w_h_moves) begin
            r_h_valid <= 1'b0;
        end
    end

    // Idle counter: counts empty cycles while an unresolved word sits in H
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_idle_cnt <= '0;
        end else if (w_h_moves || w_pop) begin
            r_idle_cnt <= '0;
        end else if (r_h_valid && !w_resolved && r_idle_cnt != c_idle_max) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
        end
    end

    // Beat counter: position of the next data beat within the frame
    always_ff @(posedge rclk) begin
        if (rrst)           r_beat_cnt <= '0;
        else if (w_h_moves) r_beat_cnt <= w_dec_last ? '0 : r_beat_cnt + BW'(1);
    end

    // Output register: holds under backpressure, reloads or drains when free
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_last  <= 1'b0;
        end else if (w_o_free) begin
            if (w_h_moves) begin
                r_o_valid <= 1'b1;
                r_o_data  <= r_h_data;
                r_o_last  <= w_move_last;
            end
`ifdef FIFO_BURST_READER_CHECKSUM_EN
            else if (w_csum_ins) begin
                r_o_valid <= 1'b1;
                r_o_data  <= r_acc;
                r_o_last  <= 1'b1;
            end
`endif
            else begin
                r_o_valid <= 1'b0;
                r_o_last  <= 1'b0;
            end
        end
    end

    // Completed-frame counter, wraps naturally
    always_ff @(posedge rclk) begin
        if (rrst)               r_bursts <= '0;
        else if (w_accept_last) r_bursts <= r_bursts + CNTW'(1);
    end
endmodule
`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the dual-clock FIFO. It lives entirely in the read clock domain.
- Drains the FIFO's first-word-fall-through read port (rdata/rempty/rinc) and repacks the words into a framed valid/ready stream.
- Frames close at BURST_LEN words, or early after the FIFO has stayed empty for TIMEOUT cycles.
- Provides the downstream counterpart to the FIFO writer, plus a completed-burst counter for status.

Parameters:
- DSIZE, 32, data word width; matches the FIFO DSIZE.
- BURST_LEN, 8, maximum data beats per frame; must be >= 2.
- TIMEOUT, 16, number of consecutive empty cycles that closes a partial frame; must be >= 1.
- CNTW, 16, width of the burst counter.

Ports:
- rclk, input, 1: read-domain clock. All logic is on the rising edge.
- rrst, input, 1: synchronous, active-high reset.
- en, input, 1: pop enable. When low, no new words are popped.
- rdata, input, DSIZE: FIFO read data. Valid whenever rempty=0.
- rempty, input, 1: FIFO empty flag.
- rinc, output, 1: FIFO pop strobe. Combinational.
- m_valid, output, 1: output beat valid.
- m_data, output, DSIZE: output beat data.
- m_last, output, 1: final beat of the frame.
- m_ready, input, 1: downstream accept.
- bursts_done, output, CNTW: count of completed frames. Wraps.
- busy, output, 1: high when a frame is open or any stage holds data.

Behaviour:
- Reset (rrst=1 at an edge) clears all state:
  - m_valid=0, m_data=0, m_last=0, bursts_done=0, busy=0.
  - Hold stage empty; beat_cnt=0; idle_cnt=0; state=STREAM.
  - rinc=0 while rrst=1.
  - A word that was popped but not yet delivered is discarded.
- Pipeline: FIFO -> hold register H -> output register O.
  - rinc = en & ~rempty & ~rrst & (~H_valid | H_moves).
  - A popped word is in H one cycle later. Earliest m_valid is 2 cycles after the pop.
- O is free when m_valid=0, or when m_valid=1 and m_ready=1.
- H moves to O when H_valid, O is free, and the last decision is resolved. The decision is taken in this priority order:
  - beat_cnt == BURST_LEN-1 -> m_last=1.
  - else if rempty=0 and en=1 -> m_last=0.
  - else if idle_cnt == TIMEOUT -> m_last=1.
  - otherwise H waits.
- idle_cnt:
  - Increments (saturating at TIMEOUT) each cycle that H is valid, H is unresolved, and (rempty=1 or en=0).
  - Clears to 0 when H moves or when a new word arrives.
- beat_cnt:
  - Increments on each H->O move with m_last=0.
  - Clears to 0 on a move with m_last=1.
- m_valid/m_data/m_last:
  - Stay stable while m_valid=1 and m_ready=0.
  - Deassert after accept if no new move occurs.
- bursts_done increments by 1 on each accepted beat with m_last=1, i.e. on an m_valid & m_ready & m_last edge. It wraps modulo 2^CNTW.
- busy = H_valid | m_valid | (beat_cnt != 0).
- en deasserting mid-frame:
  - Stops pops.
  - Words already in H/O drain normally.
  - The frame closes through the timeout.
- Simultaneous pop and H->O move in one cycle is legal; this gives a sustained throughput of 1 word/cycle.
- No FIFO underflow is possible: rinc is never asserted while rempty=1.

Optional Feature:
- Macro: FIFO_BURST_READER_CHECKSUM_EN.
- Defined:
  - Every data beat that would carry m_last=1 is instead emitted with m_last=0.
  - The next beat is an extra checksum beat: m_data = XOR of all data words of the frame, m_last=1.
  - State CSUM inserts this beat when O is free. No pop-to-O move occurs that cycle.
  - The XOR accumulator clears after the checksum beat is accepted.
  - bursts_done counts on the checksum beat.
- Not defined: no checksum beat, no accumulator, and no CSUM state.

Test Plan:
- Reset, then push 8 words 0x1..0x8 with m_ready=1 -> 8 beats in order, m_last only on 0x8. bursts_done=1. First m_valid 2 cycles after the first rinc.
- Push 3 words 0xA,0xB,0xC, then leave the FIFO empty (TIMEOUT=16) -> 0xA and 0xB emitted with m_last=0. 0xC emitted with m_last=1 after 16 empty cycles. beat_cnt returns to 0.
- Push 20 words with m_ready toggling 1,0 every cycle -> no loss or duplication. Frames of 8, 8, then 4 (the 4-beat frame closes via timeout). m_data is stable during stall cycles. bursts_done=3.
- Set en=0 with the FIFO non-empty -> rinc stays 0 and nothing is emitted. Set en=1 -> draining resumes.
- Assert rrst mid-frame with H and O full -> next cycle m_valid=0, bursts_done=0, busy=0. Post-reset words start a fresh frame.
- With FIFO_BURST_READER_CHECKSUM_EN defined, push 0x0F,0xF0 and then timeout -> beats 0x0F (last=0), 0xF0 (last=0), 0xFF (last=1). bursts_done=1.
